branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side partner of the execute-stage branch comparator. It predicts conditional-branch direction at fetch using a table of 2-bit saturating counters and records each prediction in an in-flight queue. When the comparator's resolved outcome arrives, it retires the matching prediction, trains the table, and on a mismatch issues a one-cycle redirect/flush to the PC logic.

## Interface
Parameters:
- IDX_BITS, 6: counter table index width; the table holds 2^IDX_BITS entries indexed by pc[IDX_BITS+1:2].
- INFLIGHT, 4: depth of the in-flight prediction queue, from 2 to 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_valid  in  1  fetch presents f_pc this cycle.
- f_pc  in  32  fetch PC.
- f_is_branch  in  1  predecode flags a conditional branch (opcode 1100011).
- f_imm  in  32  sign-extended B-type immediate.
- f_taken  out  1  predicted direction (combinational).
- f_next_pc  out  32  predicted next PC (combinational).
- f_stall  out  1  queue full; fetch must hold.
- r_valid  in  1  a conditional branch resolves in execute this cycle.
- r_brop  in  5  BrOp of the resolving branch.
- r_taken  in  1  resolved outcome from the comparator.
- r_pc  in  32  PC of the resolving branch.
- r_target  in  32  resolved taken target.
- redirect  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  32  corrected PC, valid while redirect is high.
- err  out  1  sticky protocol error.

## Operation
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
  - Predict taken when the counter MSB is 1.
  - On training, a taken outcome increments and a not-taken outcome decrements, both saturating.
- Fetch outputs:
  - f_taken = f_is_branch and counter MSB at index(f_pc).
  - f_next_pc = f_taken ? f_pc+f_imm : f_pc+4, with modulo-2^32 wrap.
- Queue push occurs when f_valid & f_is_branch & !f_stall & !redirect. The entry stores {pred_taken}.
- Queue pop occurs when r_valid with the queue non-empty.
  - Mispredict = head.pred_taken != r_taken.
  - The counter at index(r_pc) is trained only when r_brop is one of BEQ 01000, BNE 01001, BLT 01100, BGE 01101, BLTU 01110, BGEU 01111.
  - Any other r_brop pops the entry without training and without a mispredict.
- On mispredict:
  - Next cycle: redirect=1 and redirect_pc = r_taken ? r_target : r_pc+4.
  - At the same edge the entire queue is cleared, including any push attempted in that cycle.
- While redirect=1, pushes are suppressed because that fetch is wrong-path.
- r_valid with an empty queue sets err; no training and no redirect occur. err is cleared only by rst.

## Timing
- Reset values:
  - Every counter = WNT.
  - Queue empty, so f_stall=0.
  - redirect=0, redirect_pc=0, err=0.
- Prediction has zero latency: f_taken and f_next_pc are combinational from f_pc.
- Training is written at the edge ending the r_valid cycle. A same-cycle fetch to the same index sees the pre-update value (no bypass).
- Redirect latency is 1 cycle after r_valid. The redirect pulse is exactly 1 cycle wide, even if the next cycle also resolves.
- r_valid during a redirect cycle is ignored: no pop and no training, because it is wrong-path.
- f_stall = (count == INFLIGHT).
  - Pop and push in the same cycle while full is not possible, since stall blocks the push.
  - Pop and push in the same cycle while not full keeps count unchanged.
- rst asserted mid-operation discards all entries and any pending redirect at that edge.

## Configuration
- BP_PERF_EN:
  - When defined, adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on every trained pop and stat_mispredicts on every redirect.
  - Both reset to 0 and wrap at 2^32.
  - When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package bp_pkg holds:
  - BrOp localparams BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - The counter enum (SNT/WNT/WT/ST).
  - The queue entry typedef.
- Sub-module bp_inflight_fifo provides a parameterised synchronous FIFO with push, pop, clear, full, empty and count. The counter table and redirect logic stay in the top.

## Test plan
- Reset, then fetch f_pc=0x100, f_is_branch=1, f_imm=0x20 -> f_taken=0, f_next_pc=0x104.
- Resolve twice taken, BEQ at 0x100 -> the first resolve (pred 0) gives redirect=1 one cycle later with redirect_pc=r_target; the counter moves to ST after the second; the next fetch of 0x100 gives f_taken=1, f_next_pc=0x120.
- Push INFLIGHT branches without resolves -> f_stall=1; one r_valid -> f_stall=0 next cycle.
- Mispredict with 3 entries queued -> queue empty after the redirect edge; a fetch during the redirect cycle is not pushed.
- r_valid on an empty queue -> err=1 stays set, no redirect; r_brop=10111 with a queued entry -> pop only, no training, no redirect.
- With BP_PERF_EN: 4 branches, 1 mispredict -> stat_branches=4, stat_mispredicts=1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the fetch-side branch predictor: BrOp codes, 2-bit counter
// states, the in-flight queue entry and the counter helper functions.
package bp_pkg;

  localparam logic [4:0] BR_BEQ  = 5'b01000;
  localparam logic [4:0] BR_BNE  = 5'b01001;
  localparam logic [4:0] BR_BLT  = 5'b01100;
  localparam logic [4:0] BR_BGE  = 5'b01101;
  localparam logic [4:0] BR_BLTU = 5'b01110;
  localparam logic [4:0] BR_BGEU = 5'b01111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic pred_taken;
  } bp_entry_t;

  localparam int ENTRY_W = $bits(bp_entry_t);

  function automatic logic isCondBrOp(input logic [4:0] op);
    return (op == BR_BEQ)  || (op == BR_BNE)  || (op == BR_BLT) ||
           (op == BR_BGE)  || (op == BR_BLTU) || (op == BR_BGEU);
  endfunction

  // Saturating step toward the resolved direction.
  function automatic ctr_e ctrNext(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Parameterised synchronous FIFO holding predictions awaiting resolution;
// clear empties it at the edge regardless of a simultaneous push or pop.
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit counter branch predictor with in-flight queue and redirect.
// Optional build macro BP_PERF_EN adds branch / mispredict statistic counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_is_branch,
  input  logic [31:0] f_imm,
  output logic        f_taken,
  output logic [31:0] f_next_pc,
  output logic        f_stall,
  input  logic        r_valid,
  input  logic [4:0]  r_brop,
  input  logic        r_taken,
  input  logic [31:0] r_pc,
  input  logic [31:0] r_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        err
`ifdef BP_PERF_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int TABLE_SIZE = 1 << IDX_BITS;
  localparam int CNT_W      = $clog2(INFLIGHT + 1);

  ctr_e                r_table [TABLE_SIZE];
  logic                r_redirect;
  logic [31:0]         r_redirectPc;
  logic                r_err;

  logic [IDX_BITS-1:0] w_fIdx;
  logic [IDX_BITS-1:0] w_rIdx;
  logic [1:0]          w_fCtr;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic                w_push;
  logic                w_resolve;
  logic                w_pop;
  logic                w_train;
  logic                w_mispredict;
  logic [ENTRY_W-1:0]  w_headBits;
  bp_entry_t           w_head;
  bp_entry_t           w_newEntry;

  assign w_fIdx    = f_pc[IDX_BITS+1:2];
  assign w_rIdx    = r_pc[IDX_BITS+1:2];
  assign w_fCtr    = r_table[w_fIdx];
  assign f_taken   = f_is_branch && w_fCtr[1];
  assign f_next_pc = f_pc + (f_taken ? f_imm : 32'd4);
  assign f_stall   = (w_count == CNT_W'(INFLIGHT));

  // A redirect cycle is wrong-path on both the fetch and the resolve side.
  assign w_push       = f_valid && f_is_branch && !w_full && !r_redirect;
  assign w_resolve    = r_valid && !r_redirect;
  assign w_pop        = w_resolve && !w_empty;
  assign w_train      = w_pop && isCondBrOp(r_brop);
  assign w_head       = bp_entry_t'(w_headBits);
  assign w_mispredict = w_train && (w_head.pred_taken != r_taken);

  assign w_newEntry.pred_taken = f_taken;

  bp_inflight_fifo #(
    .DEPTH(INFLIGHT),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(w_mispredict),
    .i_data (w_newEntry),
    .o_data (w_headBits),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TABLE_SIZE; i++) r_table[i] <= WNT;
    end else if (w_train) begin
      r_table[w_rIdx] <= ctrNext(r_table[w_rIdx], r_taken);
    end
  end

  // Mispredicts are only accepted outside a redirect, so the pulse is one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect   <= 1'b0;
      r_redirectPc <= '0;
      r_err        <= 1'b0;
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict) r_redirectPc <= r_taken ? r_target : r_pc + 32'd4;
      if (w_resolve && w_empty) r_err <= 1'b1;
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirectPc;
  assign err         = r_err;

`ifdef BP_PERF_EN
  logic [31:0] r_statBranches;
  logic [31:0] r_statMispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_statBranches    <= '0;
      r_statMispredicts <= '0;
    end else begin
      if (w_train)      r_statBranches    <= r_statBranches + 32'd1;
      if (w_mispredict) r_statMispredicts <= r_statMispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_statBranches;
  assign stat_mispredicts = r_statMispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected fetch and
// redirect responses, a monitor pops and compares them as the DUT presents them.
module tb_branch_predictor;

  localparam logic [4:0] BEQ  = 5'b01000;
  localparam logic [4:0] BNE  = 5'b01001;
  localparam logic [4:0] BLT  = 5'b01100;
  localparam logic [4:0] BGEU = 5'b01111;
  localparam logic [4:0] BOTH = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid, f_is_branch, f_taken, f_stall;
  logic [31:0] f_pc, f_imm, f_next_pc;
  logic        r_valid, r_taken;
  logic [4:0]  r_brop;
  logic [31:0] r_pc, r_target;
  logic        redirect, err;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  typedef struct {
    logic        taken;
    logic [31:0] nextPc;
    logic        stall;
    logic        err;
    logic        chkRpc;
  } fetchExp_t;

  fetchExp_t   predQ[$];
  logic [31:0] redirQ[$];
  int          assertions = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .INFLIGHT(4)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pc(f_pc), .f_is_branch(f_is_branch), .f_imm(f_imm),
    .f_taken(f_taken), .f_next_pc(f_next_pc), .f_stall(f_stall),
    .r_valid(r_valid), .r_brop(r_brop), .r_taken(r_taken), .r_pc(r_pc),
    .r_target(r_target), .redirect(redirect), .redirect_pc(redirect_pc), .err(err)
`ifdef BP_PERF_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectFetch(input logic taken, input logic [31:0] nextPc,
                             input logic stall, input logic errV, input logic chkRpc = 1'b0);
    fetchExp_t e;
    e.taken = taken; e.nextPc = nextPc; e.stall = stall; e.err = errV; e.chkRpc = chkRpc;
    predQ.push_back(e);
  endtask

  task automatic expectRedirect(input logic [31:0] pc);
    redirQ.push_back(pc);
  endtask

  // Drives one cycle of fetch and resolve inputs, then advances past the edge.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic isBr,
                               input logic [31:0] imm, input logic rv, input logic [4:0] op,
                               input logic rt, input logic [31:0] rpc, input logic [31:0] rtgt);
    f_valid = fv; f_pc = pc; f_is_branch = isBr; f_imm = imm;
    r_valid = rv; r_brop = op; r_taken = rt; r_pc = rpc; r_target = rtgt;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic isBr, input logic [31:0] imm);
    applyStimulus(1'b1, pc, isBr, imm, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic resolve(input logic [4:0] op, input logic rt, input logic [31:0] rpc,
                         input logic [31:0] rtgt);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, op, rt, rpc, rtgt);
  endtask

  // Monitor: compares whenever fetch is presented or a redirect pulse appears.
  initial begin
    fetchExp_t e;
    logic [31:0] rp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (f_valid) begin
          if (predQ.size() == 0) begin
            checkOutput("unexpected_fetch", 32'd1, 32'd0);
          end else begin
            e = predQ.pop_front();
            checkOutput("f_taken", {31'd0, f_taken}, {31'd0, e.taken});
            checkOutput("f_next_pc", f_next_pc, e.nextPc);
            checkOutput("f_stall", {31'd0, f_stall}, {31'd0, e.stall});
            checkOutput("err", {31'd0, err}, {31'd0, e.err});
            if (e.chkRpc) checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
          end
        end
        if (redirect) begin
          if (redirQ.size() == 0) begin
            checkOutput("unexpected_redirect", 32'd1, 32'd0);
          end else begin
            rp = redirQ.pop_front();
            checkOutput("redirect_pc", redirect_pc, rp);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    f_valid = 0; f_pc = 0; f_is_branch = 0; f_imm = 0;
    r_valid = 0; r_brop = 0; r_taken = 0; r_pc = 0; r_target = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold counter is WNT: not taken, then two taken resolves saturate it.
    expectFetch(0, 32'h104, 0, 0, 1); fetch(32'h100, 1, 32'h20);
    expectRedirect(32'h120);          resolve(BEQ, 1, 32'h100, 32'h120);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectFetch(1, 32'h120, 0, 0);    fetch(32'h100, 1, 32'h20);
    resolve(BEQ, 1, 32'h100, 32'h120);
    expectFetch(1, 32'h120, 0, 0);    fetch(32'h100, 1, 32'h20);
    resolve(BEQ, 1, 32'h100, 32'h120);

    // Fill the queue, observe stall, release with one resolve.
    expectFetch(1, 32'h240, 0, 0);    fetch(32'h200, 1, 32'h40);
    expectFetch(0, 32'h208, 0, 0);    fetch(32'h204, 1, 32'h40);
    expectFetch(0, 32'h20C, 0, 0);    fetch(32'h208, 1, 32'h40);
    expectFetch(0, 32'h210, 0, 0);    fetch(32'h20C, 1, 32'h40);
    expectFetch(1, 32'h308, 1, 0);    fetch(32'h300, 1, 32'h8);
    expectFetch(1, 32'h308, 1, 0);
    applyStimulus(1, 32'h300, 1, 32'h8, 1, BEQ, 1, 32'h200, 32'h240);
    expectFetch(0, 32'h404, 0, 0);    fetch(32'h400, 0, 32'h0);

    // Mispredict with three queued; same-cycle push and redirect-cycle work dropped.
    expectFetch(1, 32'h610, 0, 0);    expectRedirect(32'h500);
    applyStimulus(1, 32'h600, 1, 32'h10, 1, BNE, 1, 32'h204, 32'h500);
    expectFetch(1, 32'h614, 0, 0);
    applyStimulus(1, 32'h604, 1, 32'h10, 1, BEQ, 0, 32'h208, 32'h0);
    expectFetch(0, 32'h704, 0, 0);
    applyStimulus(1, 32'h700, 0, 32'h0, 1, BEQ, 1, 32'h20C, 32'h700);

    // Sticky err; untrained BrOp pops without training.
    expectFetch(0, 32'h210, 0, 1);    fetch(32'h20C, 1, 32'h40);
    resolve(BOTH, 1, 32'h20C, 32'h700);
    expectFetch(0, 32'h210, 0, 1);    fetch(32'h20C, 1, 32'h40);
    resolve(BGEU, 0, 32'h20C, 32'h0);
    expectFetch(0, 32'h210, 0, 1);    fetch(32'h20C, 1, 32'h40);
    expectRedirect(32'h800);          resolve(BLT, 1, 32'h20C, 32'h800);
    expectFetch(0, 32'h210, 0, 1);
    applyStimulus(1, 32'h20C, 1, 32'h40, 1, BLT, 1, 32'h20C, 32'h900);
    expectFetch(0, 32'h210, 0, 1);    fetch(32'h20C, 0, 32'h40);

    // Not-taken mispredict redirects to pc+4 and weakens the counter.
    expectFetch(1, 32'h120, 0, 1);    fetch(32'h100, 1, 32'h20);
    expectRedirect(32'h104);          resolve(BEQ, 0, 32'h100, 32'h120);
    expectFetch(1, 32'h120, 0, 1);    fetch(32'h100, 1, 32'h20);
    expectFetch(1, 32'h120, 0, 1);    fetch(32'h100, 1, 32'h20);

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pending_fetch_expectations", predQ.size(), 32'd0);
    checkOutput("pending_redirect_expectations", redirQ.size(), 32'd0);
`ifdef BP_PERF_EN
    checkOutput("stat_branches", stat_branches, 32'd8);
    checkOutput("stat_mispredicts", stat_mispredicts, 32'd4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
